// File: rtl/tangram_scene_render.sv
// tangram_scene_render
//   Holds NUM_PIECES tangram pieces and tests all of them against the current
//   VGA pixel in parallel. The lowest-indexed hit wins, and the result is a
//   per-pixel colour index. Piece edits go into a shadow table. The shadow
//   table is copied into the active table at a frame boundary, so the scene
//   never tears mid-frame.
//
//   Pipeline: s1 geometry/hit -> s2 priority -> s3 vidon gating (3 clocks).
//
// Ports
//   clk_40m, rst_n          pixel clock, synchronous active-low reset
//   hc, vc, vidon           current pixel and active-video flag
//   frame_start             start-of-vblank pulse (commit point)
//   cfg_we .. cfg_color     shadow-table write port
//   commit                  request shadow->active copy at next frame_start
//   commit_pending          copy requested but not yet applied
//   pix_color, pix_hit_idx  winning colour / slot, 0 when none or blanked
//   pix_valid               vidon delayed to match pix_color
module tangram_scene_render #(
  parameter int NUM_PIECES = 7,
  parameter int COORD_W    = 11,
  parameter int SIZE_W     = 10,
  parameter int COLOR_W    = 3,
  localparam int IW        = (NUM_PIECES > 1) ? $clog2(NUM_PIECES) : 1
) (
  input  logic               clk_40m,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  logic               vidon,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_shape,
  input  logic [1:0]         cfg_toward,
  input  logic [SIZE_W-1:0]  cfg_size,
  input  logic [COORD_W-1:0] cfg_px,
  input  logic [COORD_W-1:0] cfg_py,
  input  logic [COLOR_W-1:0] cfg_color,
  input  logic               commit,
  output logic               commit_pending,
  output logic [COLOR_W-1:0] pix_color,
  output logic [IW-1:0]      pix_hit_idx,
  output logic               pix_valid
);

  localparam int W = COORD_W + 3;

  // Shadow (written by cfg port) and active (read by the pixel path) tables
  logic [NUM_PIECES-1:0]              sh_en_q, ac_en_q;
  logic [NUM_PIECES-1:0][1:0]         sh_shape_q, ac_shape_q;
  logic [NUM_PIECES-1:0][1:0]         sh_tw_q, ac_tw_q;
  logic [NUM_PIECES-1:0][SIZE_W-1:0]  sh_size_q, ac_size_q;
  logic [NUM_PIECES-1:0][COORD_W-1:0] sh_px_q, ac_px_q;
  logic [NUM_PIECES-1:0][COORD_W-1:0] sh_py_q, ac_py_q;
  logic [NUM_PIECES-1:0][COLOR_W-1:0] sh_col_q, ac_col_q;

  logic pend_q, pend_d, copy;

  // A commit arriving with frame_start is applied immediately.
  assign copy   = frame_start & (pend_q | commit);
  assign pend_d = copy ? 1'b0 : (pend_q | commit);

  always_ff @(posedge clk_40m) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      sh_en_q    <= '0;  ac_en_q    <= '0;
      sh_shape_q <= '0;  ac_shape_q <= '0;
      sh_tw_q    <= '0;  ac_tw_q    <= '0;
      sh_size_q  <= '0;  ac_size_q  <= '0;
      sh_px_q    <= '0;  ac_px_q    <= '0;
      sh_py_q    <= '0;  ac_py_q    <= '0;
      sh_col_q   <= '0;  ac_col_q   <= '0;
    end else begin
      pend_q <= pend_d;
      // Copy reads the pre-write shadow values (non-blocking semantics).
      if (copy) begin
        ac_en_q    <= sh_en_q;
        ac_shape_q <= sh_shape_q;
        ac_tw_q    <= sh_tw_q;
        ac_size_q  <= sh_size_q;
        ac_px_q    <= sh_px_q;
        ac_py_q    <= sh_py_q;
        ac_col_q   <= sh_col_q;
      end
      // Out-of-range cfg_idx matches no slot and is dropped.
      for (int i = 0; i < NUM_PIECES; i++) begin
        if (cfg_we && cfg_idx == IW'(i)) begin
          sh_en_q[i]    <= cfg_en;
          sh_shape_q[i] <= cfg_shape;
          sh_tw_q[i]    <= cfg_toward;
          sh_size_q[i]  <= cfg_size;
          sh_px_q[i]    <= cfg_px;
          sh_py_q[i]    <= cfg_py;
          sh_col_q[i]   <= cfg_color;
        end
      end
    end
  end

  assign commit_pending = pend_q;

  // Inside test for one piece; all comparisons strict, s=0 never hits.
  function automatic logic inside_f(
    input logic [1:0]         shape,
    input logic [1:0]         tw,
    input logic [SIZE_W-1:0]  size,
    input logic [COORD_W-1:0] h,
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py
  );
    logic signed [W-1:0] dx, dy, s, ns, s2, ns2, sm, df, rd;
    logic r;
    dx  = $signed({3'b000, h}) - $signed({3'b000, px});
    dy  = $signed({3'b000, v}) - $signed({3'b000, py});
    s   = $signed({{(W-SIZE_W){1'b0}}, size});
    ns  = -s;
    s2  = s <<< 1;
    ns2 = -s2;
    sm  = dx + dy;
    df  = dx - dy;
    rd  = dy - dx;
    r   = 1'b0;
    case (shape)
      2'b00: case (tw)
        2'd0:    r = (dy < 0) && (sm > ns) && (df < s);
        2'd1:    r = (dx > 0) && (sm < s)  && (df < s);
        2'd2:    r = (dy > 0) && (rd < s)  && (sm < s);
        default: r = (dx < 0) && (rd < s)  && (sm > ns);
      endcase
      2'b01: case (tw)
        2'd0:    r = (dx < 0) && (dy > 0) && (rd < s);
        2'd1:    r = (dx < 0) && (dy < 0) && (sm > ns);
        2'd2:    r = (dx > 0) && (dy < 0) && (df < s);
        default: r = (dx > 0) && (dy > 0) && (sm < s);
      endcase
      2'b10: case (tw)
        2'd0:    r = (dx > ns) && (dx < 0) && (rd > ns2) && (rd < 0);
        2'd1:    r = (dy > ns) && (dy < 0) && (sm > 0)   && (sm < s2);
        2'd2:    r = (dx > 0)  && (dx < s) && (rd > 0)   && (rd < s2);
        default: r = (dy > 0)  && (dy < s) && (sm > ns2) && (sm < 0);
      endcase
      default: r = (rd < s) && (rd > ns) && (sm < s) && (sm > ns);
    endcase
    return r && (size != '0);
  endfunction

  // Stage 1: hit vector; colours are captured alongside so a table copy
  // between stages cannot pair one frame's geometry with another's colour.
  logic [NUM_PIECES-1:0]              hit1_d, hit1_q;
  logic [NUM_PIECES-1:0][COLOR_W-1:0] col1_q;

  always_comb begin
    hit1_d = '0;
    for (int i = 0; i < NUM_PIECES; i++)
      hit1_d[i] = ac_en_q[i] && inside_f(ac_shape_q[i], ac_tw_q[i], ac_size_q[i],
                                         hc, vc, ac_px_q[i], ac_py_q[i]);
  end

  // Stage 2: lowest index wins (scan high to low so low overrides).
  logic [COLOR_W-1:0] col2_d, col2_q;
  logic [IW-1:0]      idx2_d, idx2_q;

  always_comb begin
    col2_d = '0;
    idx2_d = '0;
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (hit1_q[i]) begin
        col2_d = col1_q[i];
        idx2_d = IW'(i);
      end
    end
  end

  // vld_pipe_q[k] is vidon delayed k+1 clocks.
  logic [2:0]         vld_pipe_q;
  logic [COLOR_W-1:0] col3_q;
  logic [IW-1:0]      idx3_q;

  always_ff @(posedge clk_40m) begin
    if (!rst_n) begin
      hit1_q     <= '0;
      col1_q     <= '0;
      col2_q     <= '0;
      idx2_q     <= '0;
      col3_q     <= '0;
      idx3_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      hit1_q     <= hit1_d;
      col1_q     <= ac_col_q;
      col2_q     <= col2_d;
      idx2_q     <= idx2_d;
      col3_q     <= vld_pipe_q[1] ? col2_q : '0;
      idx3_q     <= vld_pipe_q[1] ? idx2_q : '0;
      vld_pipe_q <= {vld_pipe_q[1:0], vidon};
    end
  end

  assign pix_color   = col3_q;
  assign pix_hit_idx = idx3_q;
  assign pix_valid   = vld_pipe_q[2];

endmodule

// File: tb/tb_tangram_scene_render.sv
module tb_tangram_scene_render;

  logic        clk_40m = 1'b0;
  logic        rst_n;
  logic [10:0] hc, vc;
  logic        vidon, frame_start, cfg_we, cfg_en, commit;
  logic [2:0]  cfg_idx;
  logic [1:0]  cfg_shape, cfg_toward;
  logic [9:0]  cfg_size;
  logic [10:0] cfg_px, cfg_py;
  logic [2:0]  cfg_color;
  logic        commit_pending, pix_valid;
  logic [2:0]  pix_color, pix_hit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  tangram_scene_render dut (
    .clk_40m(clk_40m), .rst_n(rst_n), .hc(hc), .vc(vc), .vidon(vidon),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_en(cfg_en), .cfg_shape(cfg_shape), .cfg_toward(cfg_toward),
    .cfg_size(cfg_size), .cfg_px(cfg_px), .cfg_py(cfg_py),
    .cfg_color(cfg_color), .commit(commit), .commit_pending(commit_pending),
    .pix_color(pix_color), .pix_hit_idx(pix_hit_idx), .pix_valid(pix_valid)
  );

  always #5 clk_40m = ~clk_40m;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_40m); #1;
  endtask

  task automatic cfg(input int idx, input bit en, input int shp, input int tw,
                     input int sz, input int px, input int py, input int col);
    cfg_idx = 3'(idx); cfg_en = en; cfg_shape = 2'(shp); cfg_toward = 2'(tw);
    cfg_size = 10'(sz); cfg_px = 11'(px); cfg_py = 11'(py); cfg_color = 3'(col);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1; tick(); commit = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  // Hold one pixel for 3 clocks and check the registered result.
  task automatic probe(input string tag, input int h, input int v, input bit vid,
                       input int ec, input int ei);
    hc = 11'(h); vc = 11'(v); vidon = vid;
    repeat (3) @(posedge clk_40m);
    #1;
    chk({tag, ".col"}, pix_color, ec);
    chk({tag, ".idx"}, pix_hit_idx, ei);
    chk({tag, ".vld"}, pix_valid, vid);
  endtask

  initial begin
    int exp_c [$];
    rst_n = 1'b0; hc = '0; vc = '0; vidon = 1'b0; frame_start = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_shape = '0; cfg_toward = '0;
    cfg_size = '0; cfg_px = '0; cfg_py = '0; cfg_color = '0; commit = 1'b0;
    repeat (3) tick();
    chk("rst.col", pix_color, 0);
    chk("rst.idx", pix_hit_idx, 0);
    chk("rst.vld", pix_valid, 0);
    chk("rst.pend", commit_pending, 0);
    rst_n = 1'b1;
    tick();

    // Diamond slot 0, s=20 at (100,100), colour 5
    cfg(0, 1, 3, 0, 20, 100, 100, 5);
    pulse_commit();
    chk("commit.pend", commit_pending, 1);
    pulse_fs();
    chk("fs.pend", commit_pending, 0);

    // Pipelined sweep hc=78..122 on vc=100: one pixel per clock, output
    // for the pixel driven before edge k appears right after edge k+2.
    vc = 11'd100; vidon = 1'b1;
    for (int j = 0; j < 45 + 2; j++) begin
      if (j < 45) begin
        hc = 11'(78 + j);
        exp_c.push_back((78 + j >= 81 && 78 + j <= 119) ? 5 : 0);
      end
      tick();
      if (j >= 2) chk($sformatf("sweep.hc%0d", 78 + j - 2), pix_color, exp_c.pop_front());
    end

    // Triangle2 t3, slot 2, s=30 at (200,200), colour 3
    cfg(2, 1, 1, 3, 30, 200, 200, 3);
    pulse_commit(); pulse_fs();
    probe("t2.201_201", 201, 201, 1, 3, 2);
    probe("t2.200_201", 200, 201, 1, 0, 0);
    probe("t2.214_215", 214, 215, 1, 3, 2);
    probe("t2.215_215", 215, 215, 1, 0, 0);

    // Triangle1 t1, slot 3, s=20 at (400,400), colour 7
    cfg(3, 1, 0, 1, 20, 400, 400, 7);
    // Parallelogram t0, slot 5, s=10 at (500,500), colour 1
    cfg(5, 1, 2, 0, 10, 500, 500, 1);
    pulse_commit(); pulse_fs();
    probe("t1.405_400", 405, 400, 1, 7, 3);
    probe("t1.399_400", 399, 400, 1, 0, 0);
    probe("pg.495_490", 495, 490, 1, 1, 5);
    probe("pg.495_500", 495, 500, 1, 0, 0);

    // Overlap: slots 1 and 4 diamonds at (300,300)
    cfg(1, 1, 3, 0, 10, 300, 300, 2);
    cfg(4, 1, 3, 0, 10, 300, 300, 6);
    pulse_commit(); pulse_fs();
    probe("ovl.lo", 300, 300, 1, 2, 1);
    cfg(1, 0, 3, 0, 10, 300, 300, 2);
    pulse_commit();
    probe("ovl.before_fs", 300, 300, 1, 2, 1);
    pulse_fs();
    probe("ovl.after_fs", 300, 300, 1, 6, 4);

    // Tear-free move of slot 0 from px=100 to px=150 mid-frame
    vc = 11'd250;
    cfg(0, 1, 3, 0, 20, 150, 100, 5);
    pulse_commit();
    probe("tear.old", 100, 100, 1, 5, 0);
    probe("tear.new_hidden", 150, 100, 1, 0, 0);
    chk("tear.pend", commit_pending, 1);
    pulse_fs();
    chk("tear.pend_clr", commit_pending, 0);
    probe("tear.new", 150, 100, 1, 5, 0);
    probe("tear.old_gone", 100, 100, 1, 0, 0);

    // vidon=0 inside a piece
    probe("blank", 150, 100, 0, 0, 0);

    // Out-of-range cfg_idx
    cfg(7, 1, 3, 0, 10, 600, 600, 4);
    pulse_commit(); pulse_fs();
    probe("idx7", 600, 600, 1, 0, 0);

    // commit and frame_start together: copy now, pending stays 0
    cfg(6, 1, 3, 0, 10, 700, 100, 3);
    commit = 1'b1; frame_start = 1'b1; tick(); commit = 1'b0; frame_start = 1'b0;
    chk("same.pend", commit_pending, 0);
    probe("same.hit", 700, 100, 1, 3, 6);

    // cfg write coinciding with the copy: active gets the old shadow value
    pulse_commit();
    cfg_idx = 3'd6; cfg_en = 1'b1; cfg_shape = 2'd3; cfg_toward = 2'd0;
    cfg_size = 10'd10; cfg_px = 11'd700; cfg_py = 11'd100; cfg_color = 3'd5;
    cfg_we = 1'b1; frame_start = 1'b1;
    tick();
    cfg_we = 1'b0; frame_start = 1'b0;
    chk("wcopy.pend", commit_pending, 0);
    probe("wcopy.old", 700, 100, 1, 3, 6);
    pulse_commit(); pulse_fs();
    probe("wcopy.new", 700, 100, 1, 5, 6);

    // Reset mid-line while inside slot 4
    hc = 11'd300; vc = 11'd300; vidon = 1'b1;
    repeat (3) tick();
    chk("mid.pre", pix_color, 6);
    rst_n = 1'b0;
    tick();
    chk("mid.col", pix_color, 0);
    chk("mid.idx", pix_hit_idx, 0);
    chk("mid.vld", pix_valid, 0);
    rst_n = 1'b1;
    pulse_commit(); pulse_fs();
    probe("mid.tbl4", 300, 300, 1, 0, 0);
    probe("mid.tbl6", 700, 100, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
